// File: rtl/instq.sv
// instq: parametrised instruction queue with opcode/operand decode of the head word.
// Optional decode look-ahead port enabled by defining INSTQ_PEEK_EN.  Rev 1.0
`default_nettype none

module instq #(
  parameter int OPW   = 3,
  parameter int ARGW  = 8,
  parameter int DEPTH = 4,
  localparam int IW   = OPW + ARGW,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [IW-1:0]   in_inst,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OPW-1:0]  ALU_Sel,
  output logic [ARGW-1:0] A,
`ifdef INSTQ_PEEK_EN
  output logic            next_valid,
  output logic [OPW-1:0]  ALU_Sel_next,
  output logic [ARGW-1:0] A_next,
`endif
  output logic [CW-1:0]   count
);

  logic [IW-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;
  logic [IW-1:0] head;

  // A full queue refuses a push even if a pop happens in the same cycle.
  assign in_ready  = (cnt != CW'(DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = cnt;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

  // Storage needs no reset: nothing is visible unless the counter says so.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem[wp] <= in_inst;
  end

  assign head    = out_valid ? mem[rp] : '0;
  assign ALU_Sel = head[OPW-1:0];
  assign A       = head[IW-1:OPW];

`ifdef INSTQ_PEEK_EN
  logic [AW-1:0] rp_next;
  logic [IW-1:0] peek;

  assign rp_next      = rp + AW'(1);
  assign next_valid   = (cnt >= CW'(2));
  assign peek         = next_valid ? mem[rp_next] : '0;
  assign ALU_Sel_next = peek[OPW-1:0];
  assign A_next       = peek[IW-1:OPW];
`endif

endmodule

`default_nettype wire

// File: tb/tb_instq.sv
// tb_instq: scoreboard bench for instq; a reference queue is updated by the stimulus
// and a negedge monitor compares the DUT head/count/handshake against it.
`default_nettype none

module tb_instq;
  localparam int OPW   = 3;
  localparam int ARGW  = 8;
  localparam int DEPTH = 4;
  localparam int IW    = OPW + ARGW;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, out_ready;
  logic [IW-1:0]   in_inst;
  logic            in_ready, out_valid;
  logic [OPW-1:0]  ALU_Sel;
  logic [ARGW-1:0] A;
  logic [CW-1:0]   count;
`ifdef INSTQ_PEEK_EN
  logic            next_valid;
  logic [OPW-1:0]  ALU_Sel_next;
  logic [ARGW-1:0] A_next;
`endif

  int checks = 0;
  int errors = 0;
  logic [IW-1:0] mq[$];
  bit armed = 1'b0;

  instq #(.OPW(OPW), .ARGW(ARGW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_inst(in_inst), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALU_Sel(ALU_Sel), .A(A),
`ifdef INSTQ_PEEK_EN
    .next_valid(next_valid), .ALU_Sel_next(ALU_Sel_next), .A_next(A_next),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock: the reference queue follows the same accept rules as the queue spec.
  task automatic step();
    bit p_pop, p_push;
    @(posedge clk);
    if (rst || flush) begin
      mq.delete();
    end else begin
      p_pop  = (mq.size() != 0) && out_ready;
      p_push = in_valid && (mq.size() != DEPTH);
      if (p_pop)  void'(mq.pop_front());
      if (p_push) mq.push_back(in_inst);
    end
    #1;
  endtask

  // Monitor: whenever the DUT presents a head word it must match the scoreboard front.
  always @(negedge clk) begin
    if (armed) begin
      chk("mon_count", int'(count), mq.size());
      chk("mon_out_valid", int'(out_valid), int'(mq.size() != 0));
      chk("mon_in_ready", int'(in_ready), int'(mq.size() != DEPTH));
      if (out_valid) begin
        if (mq.size() == 0) begin
          chk("mon_unexpected_word", 1, 0);
        end else begin
          chk("mon_ALU_Sel", int'(ALU_Sel), int'(mq[0][OPW-1:0]));
          chk("mon_A", int'(A), int'(mq[0][IW-1:OPW]));
        end
      end else begin
        chk("mon_empty_ALU_Sel", int'(ALU_Sel), 0);
        chk("mon_empty_A", int'(A), 0);
      end
`ifdef INSTQ_PEEK_EN
      chk("mon_next_valid", int'(next_valid), int'(mq.size() >= 2));
      if (mq.size() >= 2) begin
        chk("mon_ALU_Sel_next", int'(ALU_Sel_next), int'(mq[1][OPW-1:0]));
        chk("mon_A_next", int'(A_next), int'(mq[1][IW-1:OPW]));
      end else begin
        chk("mon_ALU_Sel_next0", int'(ALU_Sel_next), 0);
        chk("mon_A_next0", int'(A_next), 0);
      end
`endif
    end
  end

  initial begin
    int w;
    bit acc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_inst = 11'h7FF; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0; in_valid = 1'b0;
    armed = 1'b1;
    chk("rst_count", int'(count), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_A", int'(A), 0);
    chk("rst_ALU_Sel", int'(ALU_Sel), 0);

    // Decode and one-cycle fall-through
    in_inst = 11'b10110011_101; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("dec_A", int'(A), 8'hB3);
    chk("dec_ALU_Sel", int'(ALU_Sel), 3'b101);
    chk("dec_count", int'(count), 1);
    chk("dec_out_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("dec_drain_count", int'(count), 0);

    // Fill beyond capacity: words 5 and 6 are dropped
    for (int i = 1; i <= 6; i++) begin
      in_inst = IW'(i); in_valid = 1'b1;
      step();
      if (i == 4) chk("full_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    chk("full_count", int'(count), 4);

    // Pop with concurrent push of 7..A, each word held until accepted
    out_ready = 1'b1;
    w = 7;
    for (int c = 0; c < 8; c++) begin
      in_valid = (w <= 10);
      in_inst  = IW'(w);
      acc = in_valid && (mq.size() != DEPTH);
      step();
      if (acc) w++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("wrap_all_pushed", w, 11);
    chk("wrap_count", int'(count), 0);

    // Simultaneous push/pop at cnt=2
    for (int i = 0; i < 2; i++) begin
      in_inst = IW'(11'h100 + i); in_valid = 1'b1;
      step();
    end
    in_inst = 11'h1AB; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pp2_count", int'(count), 2);
    in_inst = 11'h2C3; step();
    in_inst = 11'h3D4; step();
    chk("pp_full_count", int'(count), 4);
    in_inst = 11'h4E5; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("pp_full_count_after", int'(count), 3);

    // Flush beats a same-cycle push and pop
    flush = 1'b1; in_valid = 1'b1; in_inst = 11'h7AA; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", int'(count), 0);
    chk("flush_out_valid", int'(out_valid), 0);
    chk("flush_in_ready", int'(in_ready), 1);
    step();
    step();
    out_ready = 1'b0;

`ifdef INSTQ_PEEK_EN
    in_valid = 1'b1;
    in_inst = 11'h0A5; step();
    in_inst = 11'h15A; step();
    in_valid = 1'b0;
    chk("peek_next_valid", int'(next_valid), 1);
    chk("peek_A_next", int'(A_next), 8'h2B);
    chk("peek_ALU_Sel_next", int'(ALU_Sel_next), 3'b010);
    chk("peek_head_A", int'(A), 8'h14);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("peek_pop_next_valid", int'(next_valid), 0);
    chk("peek_pop_A_next", int'(A_next), 0);
    chk("peek_pop_ALU_Sel_next", int'(ALU_Sel_next), 0);
`endif

    step();
    armed = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
